// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: state encodings and sweep geometry.
package truth_table_checker_pkg;

   localparam int NUM_VEC = 16;
   localparam int VEC_W   = 4;
   localparam int CNT_W   = 4;
   localparam int ERR_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } ttc_state_t;

endpackage

// File: rtl/truth_table_checker_settle_counter.sv
// tt_settle_counter: loadable down-counter with terminal-count flag, times the WAIT interval.
import truth_table_checker_pkg::*;

module tt_settle_counter (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all 16 vectors into a 4-input combinational DUT and checks f against EXPECT.
// Optional macro TTC_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start after reset
// WAIT   | vec_out held for SETTLE cycles while the DUT settles
// SAMPLE | compare f_in with EXPECT[idx], advance or finish
// DONE   | results valid, waiting for a restart
import truth_table_checker_pkg::*;

module truth_table_checker #(
   parameter int unsigned SETTLE = 4,
   parameter logic [15:0] EXPECT = 16'h6996
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [VEC_W-1:0] vec_out,
   input  logic             f_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [VEC_W-1:0] first_fail_vec,
   output logic             first_fail_valid
);

`ifdef TTC_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VEC - 1);
   localparam logic [CNT_W-1:0] SETTLE_TOP = CNT_W'(SETTLE - 1);

   ttc_state_t       state_q, state_d;
   logic [VEC_W-1:0] idx_q, idx_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [VEC_W-1:0] ffv_q, ffv_d;
   logic             ffvld_q, ffvld_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             cnt_load, cnt_tc;
   logic             mismatch;

   tt_settle_counter u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (SETTLE_TOP),
      .en       (state_q == ST_WAIT),
      .tc       (cnt_tc)
   );

   assign mismatch = (f_in != EXPECT[idx_q]);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      err_d    = err_q;
      ffv_d    = ffv_q;
      ffvld_d  = ffvld_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      cnt_load = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_WAIT;
               idx_d    = '0;
               err_d    = '0;
               ffv_d    = '0;
               ffvld_d  = 1'b0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               cnt_load = 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt_tc) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (mismatch) begin
               err_d = err_q + 1'b1;
               if (!ffvld_q) begin
                  ffv_d   = idx_q;
                  ffvld_d = 1'b1;
               end
            end
            // pass must reflect this cycle's compare, hence err_d rather than err_q
            if ((idx_q == LAST_VEC) || (STOP_ON_FAIL && mismatch)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d  = ST_WAIT;
               idx_d    = idx_q + 1'b1;
               cnt_load = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         err_q   <= '0;
         ffv_q   <= '0;
         ffvld_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffvld_q <= ffvld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // vec_out is the sweep index itself, so it only moves when idx does
   assign vec_out          = idx_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvld_q;

endmodule
